life_sequencer: RTL and testbench

//  Generation controller for the NxN Game-of-Life core. Loads the seed into the core,

---
 rtl/life_sequencer_if.sv | 39 +++
 rtl/life_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_life_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/life_sequencer_if.sv
// Board-side command and core-side strobe bundle for life_sequencer.
//   master : the side issuing commands and holding the life core grid
//            (drives cmd_*, grid_in; observes strobes and status)
//   slave  : the sequencer itself
// Signals:
//   cmd_load/cmd_start/cmd_stop/cmd_step  1-cycle command pulses
//   grid_in     N*N   current core grid
//   core_load   1     strobe: core copies seed into its grid
//   core_en     1     strobe: core computes next generation
//   gen_count   GEN_W generations since last load
//   state       3     IDLE=0 LOAD=1 PAUSE=2 RUN=3 HALT=4
//   halted      1     high while in HALT
//   halt_cause  2     00 none, 01 extinct, 10 still life, 11 saturated
interface life_sequencer_if #(
  parameter int unsigned N     = 10,
  parameter int unsigned GEN_W = 16
);
  logic             cmd_load;
  logic             cmd_start;
  logic             cmd_stop;
  logic             cmd_step;
  logic [N*N-1:0]   grid_in;
  logic             core_load;
  logic             core_en;
  logic [GEN_W-1:0] gen_count;
  logic [2:0]       state;
  logic             halted;
  logic [1:0]       halt_cause;

  modport master (
    output cmd_load, cmd_start, cmd_stop, cmd_step, grid_in,
    input  core_load, core_en, gen_count, state, halted, halt_cause
  );

  modport slave (
    input  cmd_load, cmd_start, cmd_stop, cmd_step, grid_in,
    output core_load, core_en, gen_count, state, halted, halt_cause
  );
endinterface

// File: rtl/life_sequencer.sv
// Generation controller for the NxN Game-of-Life core.
// Loads the seed into the core, then advances it one generation per cmd_step
// (PAUSE) or once every TICK_DIV clocks (RUN). Counts generations since the
// last load and halts when the counter saturates.
// Optional feature macro: AUTO_HALT_EN -- when defined, the grid returned by
// the core after every generation is compared against the pre-step grid and
// the sequencer halts on extinction (cause 01) or a still life (cause 10).
// Ports:
//   clk    in  system clock, all state on the rising edge
//   reset  in  asynchronous, active-low reset
//   bus    life_sequencer_if.slave (commands in, core strobes and status out)
// Parameters: N grid edge, TICK_DIV clocks per generation in RUN (>=2),
//   DIV_W tick counter width, GEN_W generation counter width.
module life_sequencer #(
  parameter int unsigned N        = 10,
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned DIV_W    = 25,
  parameter int unsigned GEN_W    = 16
) (
  input logic             clk,
  input logic             reset,
  life_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PAUSE = 3'd2,
    S_RUN   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

  state_t           st;
  logic [DIV_W-1:0] tick;
  logic             core_load_q;
  logic             core_en_q;
  logic [GEN_W-1:0] gen_q;
  logic             halted_q;
  logic [1:0]       cause_q;

  logic [GEN_W-1:0] gen_next;
  logic             gen_sat;

  // Result of the post-generation grid check and the step interlock.
  logic             auto_hit;
  logic [1:0]       auto_cause;
  logic             step_block;

  always_comb begin
    gen_next = gen_q + 1'b1;
    gen_sat  = (gen_next == '1);
  end

`ifdef AUTO_HALT_EN
  logic [N*N-1:0] snapshot;
  logic           chk_pend;

  // The core updates its grid on the edge that ends the core_en cycle, so
  // grid_in during that cycle is still the pre-step grid: capture it, then
  // compare against the new grid one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snapshot <= '0;
      chk_pend <= 1'b0;
    end else begin
      chk_pend <= core_en_q;
      if (core_en_q) begin
        snapshot <= bus.grid_in;
      end
    end
  end

  always_comb begin
    auto_cause = 2'b00;
    if (bus.grid_in == '0) begin
      auto_cause = 2'b01;
    end else if (bus.grid_in == snapshot) begin
      auto_cause = 2'b10;
    end
    auto_hit   = chk_pend && (auto_cause != 2'b00);
    // A step landing while core_en is high would strobe during the check cycle.
    step_block = core_en_q;
  end
`else
  always_comb begin
    auto_hit   = 1'b0;
    auto_cause = 2'b00;
    step_block = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= S_IDLE;
      tick        <= '0;
      core_load_q <= 1'b0;
      core_en_q   <= 1'b0;
      gen_q       <= '0;
      halted_q    <= 1'b0;
      cause_q     <= 2'b00;
    end else begin
      core_load_q <= 1'b0;
      core_en_q   <= 1'b0;

      if (bus.cmd_load && (st != S_LOAD)) begin
        st          <= S_LOAD;
        core_load_q <= 1'b1;
        gen_q       <= '0;
        cause_q     <= 2'b00;
        halted_q    <= 1'b0;
      end else begin
        case (st)
          S_IDLE: begin
          end

          S_LOAD: begin
            st <= S_PAUSE;
          end

          S_PAUSE: begin
            // A pending auto-halt outranks any command on the check edge.
            if (auto_hit) begin
              st       <= S_HALT;
              halted_q <= 1'b1;
              cause_q  <= auto_cause;
            end else if (bus.cmd_stop) begin
              st <= S_PAUSE;
            end else if (bus.cmd_start) begin
              st   <= S_RUN;
              tick <= '0;
            end else if (bus.cmd_step && !step_block) begin
              core_en_q <= 1'b1;
              gen_q     <= gen_next;
              if (gen_sat) begin
                st       <= S_HALT;
                halted_q <= 1'b1;
                cause_q  <= 2'b11;
              end
            end
          end

          S_RUN: begin
            if (auto_hit) begin
              st       <= S_HALT;
              halted_q <= 1'b1;
              cause_q  <= auto_cause;
            end else if (bus.cmd_stop) begin
              st <= S_PAUSE;
            end else if (tick == TICK_LAST) begin
              tick      <= '0;
              core_en_q <= 1'b1;
              gen_q     <= gen_next;
              if (gen_sat) begin
                st       <= S_HALT;
                halted_q <= 1'b1;
                cause_q  <= 2'b11;
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end

          S_HALT: begin
          end

          default: begin
            st <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.core_load  = core_load_q;
  assign bus.core_en    = core_en_q;
  assign bus.gen_count  = gen_q;
  assign bus.state      = st;
  assign bus.halted     = halted_q;
  assign bus.halt_cause = cause_q;

endmodule

// File: tb/tb_life_sequencer.sv
// Scoreboard bench for life_sequencer: directed scenarios followed by random
// command traffic. A life-core model answers the DUT's strobes with real
// Game-of-Life generations; a behavioural reference predicts every cycle's
// outputs, which a separate monitor checks on the falling edge.
`timescale 1ns/1ps
module tb_life_sequencer;
  localparam int unsigned N        = 10;
  localparam int unsigned CELLS    = N * N;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned DIV_W    = 2;
  localparam int unsigned GEN_W    = 5;
  localparam int          GEN_MAX  = (1 << GEN_W) - 1;

  typedef logic [CELLS-1:0] grid_t;
  typedef struct packed {
    logic             cl;
    logic             ce;
    logic [GEN_W-1:0] gen;
    logic [2:0]       st;
    logic             h;
    logic [1:0]       cause;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  life_sequencer_if #(.N(N), .GEN_W(GEN_W)) bus ();

  life_sequencer #(
    .N(N), .TICK_DIV(TICK_DIV), .DIV_W(DIV_W), .GEN_W(GEN_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int misc    = 0;
  exp_t exp_q[$];

  // ---------------- life rules ----------------
  function automatic grid_t life_next(input grid_t g);
    grid_t r;
    int cnt, yy, xx;
    r = '0;
    for (int y = 0; y < int'(N); y++) begin
      for (int x = 0; x < int'(N); x++) begin
        cnt = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            yy = y + dy;
            xx = x + dx;
            if (!(dx == 0 && dy == 0) && yy >= 0 && yy < int'(N) && xx >= 0 && xx < int'(N))
              cnt += int'(g[yy * int'(N) + xx]);
          end
        end
        r[y * int'(N) + x] = (cnt == 3) || (g[y * int'(N) + x] && cnt == 2);
      end
    end
    return r;
  endfunction

  function automatic grid_t pick_seed(input int kind);
    grid_t g;
    g = '0;
    case (kind)
      0: g[5 * N + 5] = 1'b1;
      1: begin
        g[4 * N + 4] = 1'b1; g[4 * N + 5] = 1'b1;
        g[5 * N + 4] = 1'b1; g[5 * N + 5] = 1'b1;
      end
      2: begin
        g[5 * N + 4] = 1'b1; g[5 * N + 5] = 1'b1; g[5 * N + 6] = 1'b1;
      end
      default: for (int i = 0; i < int'(CELLS); i++) g[i] = ($urandom_range(0, 4) == 0);
    endcase
    return g;
  endfunction

  // ---------------- life core model ----------------
  grid_t seed      = '0;
  grid_t core_grid = '0;
  always @(posedge clk) begin
    if (bus.core_load)     core_grid <= seed;
    else if (bus.core_en)  core_grid <= life_next(core_grid);
  end
  assign bus.grid_in = core_grid;

  // ---------------- reference model ----------------
  // mode codes: 0 idle, 1 load, 2 pause, 3 run, 4 halt
`ifdef AUTO_HALT_EN
  bit auto_en = 1'b1;
`else
  bit auto_en = 1'b0;
`endif
  int    m_mode = 0, m_gens = 0, m_cause = 0, m_run_cycles = 0;
  int    m_chk_wait = 0, m_chk_cause = 0;
  grid_t m_grid = '0;

  function automatic exp_t pack_exp(input bit cl, input bit ce);
    exp_t e;
    e.cl    = cl;
    e.ce    = ce;
    e.gen   = m_gens[GEN_W-1:0];
    e.st    = 3'(m_mode);
    e.h     = (m_mode == 4);
    e.cause = 2'(m_cause);
    return e;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_gens = 0; m_cause = 0; m_run_cycles = 0;
    m_chk_wait = 0; m_chk_cause = 0;
  endtask

  task automatic model_edge(input bit ld, input bit sp, input bit sa, input bit ss,
                            output exp_t e);
    bit    strobe, check_now, en_now, cl;
    grid_t nxt;
    strobe    = 1'b0;
    cl        = 1'b0;
    check_now = (m_chk_wait == 1);  // second edge after a generation strobe
    en_now    = (m_chk_wait == 2);  // a strobe is on the outputs right now
    if (m_chk_wait > 0) m_chk_wait--;

    if (ld && m_mode != 1) begin
      m_mode = 1; m_gens = 0; m_cause = 0; m_grid = seed; m_chk_wait = 0; cl = 1'b1;
    end else if (m_mode == 1) begin
      m_mode = 2;
    end else if (m_mode == 2 || m_mode == 3) begin
      if (auto_en && check_now && m_chk_cause != 0) begin
        m_mode = 4; m_cause = m_chk_cause;
      end else if (m_mode == 2) begin
        if (!sp) begin
          if (sa) begin
            m_mode = 3; m_run_cycles = 0;
          end else if (ss && !(auto_en && en_now)) begin
            strobe = 1'b1;
          end
        end
      end else begin
        if (sp) m_mode = 2;
        else begin
          m_run_cycles++;
          strobe = ((m_run_cycles % TICK_DIV) == 0);
        end
      end
    end

    if (strobe) begin
      nxt = life_next(m_grid);
      m_gens++;
      m_chk_cause = (nxt == '0) ? 1 : ((nxt == m_grid) ? 2 : 0);
      m_grid      = nxt;
      m_chk_wait  = 2;
      if (m_gens == GEN_MAX) begin
        m_mode = 4; m_cause = 3;
      end
    end
    e = pack_exp(cl, strobe);
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit ld, input bit sp, input bit sa, input bit ss);
    exp_t e;
    bus.cmd_load = ld; bus.cmd_stop = sp; bus.cmd_start = sa; bus.cmd_step = ss;
    @(posedge clk);
    if (!reset) begin
      model_reset();
      e = '0;
    end else begin
      model_edge(ld, sp, sa, ss, e);
    end
    exp_q.push_back(e);
    @(negedge clk);
    bus.cmd_load = 1'b0; bus.cmd_stop = 1'b0; bus.cmd_start = 1'b0; bus.cmd_step = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input int kind);
    if (m_mode != 1) seed = pick_seed(kind);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Drops reset 1 ns after the edge that raises a generation strobe.
  task automatic reset_on_strobe();
    exp_t e;
    bit   done;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(posedge clk);
      model_edge(1'b0, 1'b0, 1'b0, 1'b0, e);
      if (e.ce) begin
        #1 reset = 1'b0;
        model_reset();
        e    = '0;
        done = 1'b1;
      end
      exp_q.push_back(e);
      @(negedge clk);
    end
    if (!done) begin
      vectors++;
      misc++;
      $display("FAIL reset_mid_run: no generation strobe within 64 cycles (required one)");
    end
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e, mon_a;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a.cl    = bus.core_load;
      mon_a.ce    = bus.core_en;
      mon_a.gen   = bus.gen_count;
      mon_a.st    = bus.state;
      mon_a.h     = bus.halted;
      mon_a.cause = bus.halt_cause;
      vectors++;
      if (mon_a !== mon_e) begin
        misc++;
        $display("FAIL outputs @%0t: got load=%0b en=%0b gen=%0d state=%0d halted=%0b cause=%0d, want load=%0b en=%0b gen=%0d state=%0d halted=%0b cause=%0d",
                 $time, mon_a.cl, mon_a.ce, mon_a.gen, mon_a.st, mon_a.h, mon_a.cause,
                 mon_e.cl, mon_e.ce, mon_e.gen, mon_e.st, mon_e.h, mon_e.cause);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.cmd_load = 1'b0; bus.cmd_stop = 1'b0; bus.cmd_start = 1'b0; bus.cmd_step = 1'b0;
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(2);

    // load, then single step
    load(2);
    idle(1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);

    // free run for ten generations, then stop exactly on a wrap edge
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(40);
    for (int i = 0; i < int'(TICK_DIV) && ((m_run_cycles + 1) % TICK_DIV) != 0; i++) idle(1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);

    // load and stop together while running
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);
    seed = pick_seed(2);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);

`ifdef AUTO_HALT_EN
    load(0); idle(1); cycle(1'b0, 1'b0, 1'b0, 1'b1); idle(4);
    load(1); idle(1); cycle(1'b0, 1'b0, 1'b0, 1'b1); idle(4);
    load(2); idle(1); cycle(1'b0, 1'b0, 1'b1, 1'b0); idle(20 * TICK_DIV + 2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0); idle(2);
`endif

    // saturation, then commands in HALT, then reload
    load(2);
    idle(1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 200 && m_mode != 4; i++) idle(1);
    idle(2);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    load(2);
    idle(3);

    // reset while a generation strobe is on the outputs
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    reset_on_strobe();
    idle(1);
    reset = 1'b1;
    idle(2);

    // random command traffic
    for (int i = 0; i < 1500; i++) begin
      bit ld, sp, sa, ss;
      ld = ($urandom_range(0, 99) < 3);
      sp = ($urandom_range(0, 99) < 4);
      sa = ($urandom_range(0, 99) < 8);
      ss = ($urandom_range(0, 99) < 20);
      if (ld && m_mode != 1) seed = pick_seed(int'($urandom_range(0, 3)));
      cycle(ld, sp, sa, ss);
    end
    idle(2);

    #2;
    if (exp_q.size() != 0) begin
      vectors++;
      misc++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete within 2 ms of simulated time");
    $fatal(1, "timeout");
  end
endmodule
